// File: rtl/parity_pkg.sv
// Shared definitions for the parity arbiter: FSM encoding, parity polarity
// constants and an index-width helper.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam bit ParityEven = 1'b0;
  localparam bit ParityOdd  = 1'b1;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_arbiter_if.sv
// Request/result bundle between requesters (master) and the parity arbiter (slave).
interface parity_arbiter_if
  import parity_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8
);

  localparam int unsigned IdW = id_width(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] din;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               done;
  logic [IdW-1:0]     done_id;
  logic               parity;

  modport master (
    output req, din,
    input  gnt, busy, done, done_id, parity
  );

  modport slave (
    input  req, din,
    output gnt, busy, done, done_id, parity
  );

endinterface

// File: rtl/parity_xor_w.sv
// XOR reduction of one W-bit operand; shared by all requesters.
module parity_xor_w #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] data,
  output logic         parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_arbiter.sv
// Round-robin arbiter that latches the winner's operand and returns its parity.
// One operation every three cycles: IDLE (grant) -> CALC -> RESP (done).
module parity_arbiter
  import parity_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned ODD   = 0
) (
  input logic             clk,
  input logic             reset,
  parity_arbiter_if.slave bus
);

  localparam int unsigned IdW = id_width(N_REQ);
  localparam bit          Pol = (ODD != 0) ? ParityOdd : ParityEven;

  state_e           state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [IdW-1:0]   id_q, id_d;
  logic [IdW-1:0]   done_id_q, done_id_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]     operand_q, operand_d;
  logic             done_q, done_d;
  logic             parity_q, parity_d;
  logic             busy_q, busy_d;
  logic             xor_out;

  int unsigned      win;
  int unsigned      best_dist;
  logic             win_valid;
  logic [N_REQ-1:0] win_oh;
  logic [W-1:0]     win_op;

  // Winner is the requester at the smallest forward distance from ptr.
  always_comb begin
    win       = 0;
    best_dist = N_REQ;
    win_valid = 1'b0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (bus.req[j] && (((j + N_REQ - 32'(ptr_q)) % N_REQ) < best_dist)) begin
        win       = j;
        best_dist = (j + N_REQ - 32'(ptr_q)) % N_REQ;
        win_valid = 1'b1;
      end
    end
    win_oh = '0;
    win_op = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (j == win) begin
        win_oh[j] = 1'b1;
        win_op    = bus.din[j*W +: W];
      end
    end
  end

  parity_xor_w #(
    .W(W)
  ) u_xor (
    .data  (operand_q),
    .parity(xor_out)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    gnt_d     = gnt_q;
    operand_d = operand_q;
    done_d    = done_q;
    done_id_d = done_id_q;
    parity_d  = parity_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          operand_d = win_op;
          gnt_d     = win_oh;
          id_d      = IdW'(win);
          state_d   = StCalc;
        end
      end
      StCalc: begin
        parity_d  = xor_out ^ Pol;
        done_d    = 1'b1;
        done_id_d = id_q;
        gnt_d     = '0;
        state_d   = StResp;
      end
      StResp: begin
        done_d  = 1'b0;
        ptr_d   = (id_q == IdW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      operand_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      parity_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      operand_q <= operand_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      parity_q  <= parity_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.parity  = parity_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// Directed bench for parity_arbiter: one even-parity and one odd-parity instance.
module tb_parity_arbiter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  parity_arbiter_if #(.N_REQ(4), .W(8)) bus_even ();
  parity_arbiter_if #(.N_REQ(4), .W(8)) bus_odd ();

  parity_arbiter #(.N_REQ(4), .W(8), .ODD(0)) dut_even (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_even.slave)
  );

  parity_arbiter #(.N_REQ(4), .W(8), .ODD(1)) dut_odd (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_odd.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus_even.req = '0;
    bus_odd.req  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus_even.req = '0;
    bus_odd.req  = '0;
    bus_even.din = '0;
    bus_odd.din  = '0;
    tick();
    tick();
    tests++; if (bus_even.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", bus_even.gnt); end
    tests++; if (bus_even.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus_even.busy); end
    tests++; if (bus_even.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus_even.done); end
    tests++; if (bus_even.done_id !== 2'd0) begin fails++; $display("FAIL reset_done_id: got %0d expected 0", bus_even.done_id); end
    tests++; if (bus_odd.parity !== 1'b0) begin fails++; $display("FAIL reset_parity_odd: got %b expected 0", bus_odd.parity); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bus_even.din = {8'h00, 8'h00, 8'h00, 8'hA5};
    bus_even.req = 4'b0001;
    tick();
    tests++; if (bus_even.gnt !== 4'b0001) begin fails++; $display("FAIL single_gnt: got %b expected 0001", bus_even.gnt); end
    tests++; if (bus_even.busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", bus_even.busy); end
    tests++; if (bus_even.done !== 1'b0) begin fails++; $display("FAIL single_early_done: got %b expected 0", bus_even.done); end
    bus_even.req = 4'b0000;
    tick();
    tests++; if (bus_even.done !== 1'b1) begin fails++; $display("FAIL single_done: got %b expected 1", bus_even.done); end
    tests++; if (bus_even.done_id !== 2'd0) begin fails++; $display("FAIL single_done_id: got %0d expected 0", bus_even.done_id); end
    tests++; if (bus_even.parity !== 1'b0) begin fails++; $display("FAIL single_parity: got %b expected 0", bus_even.parity); end
    tests++; if (bus_even.gnt !== 4'b0000) begin fails++; $display("FAIL single_gnt_drop: got %b expected 0000", bus_even.gnt); end
    tick();
    tests++; if (bus_even.done !== 1'b0) begin fails++; $display("FAIL single_done_pulse: got %b expected 0", bus_even.done); end
    tests++; if (bus_even.busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b expected 0", bus_even.busy); end
    tests++; if (bus_even.parity !== 1'b0 || bus_even.done_id !== 2'd0) begin
      fails++; $display("FAIL single_hold: got parity %b id %0d expected 0 0", bus_even.parity, bus_even.done_id);
    end
  endtask

  task automatic test_odd();
    bus_odd.din = {8'h00, 8'h07, 8'h00, 8'h00};
    bus_odd.req = 4'b0100;
    tick();
    tests++; if (bus_odd.gnt !== 4'b0100) begin fails++; $display("FAIL odd_gnt: got %b expected 0100", bus_odd.gnt); end
    bus_odd.req = 4'b0000;
    tick();
    tests++; if (bus_odd.done !== 1'b1) begin fails++; $display("FAIL odd_done: got %b expected 1", bus_odd.done); end
    tests++; if (bus_odd.done_id !== 2'd2) begin fails++; $display("FAIL odd_done_id: got %0d expected 2", bus_odd.done_id); end
    tests++; if (bus_odd.parity !== 1'b0) begin fails++; $display("FAIL odd_parity: got %b expected 0", bus_odd.parity); end
    tick();
  endtask

  task automatic test_round_robin();
    bit         par_tbl [0:4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] oh_tbl  [0:4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] id_tbl  [0:4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus_even.din = {8'h0F, 8'h07, 8'h03, 8'h01};
    bus_even.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (bus_even.gnt !== oh_tbl[k] || bus_even.done !== 1'b0) begin
        fails++; $display("FAIL rr_gnt[%0d]: got gnt %b done %b expected %b 0", k, bus_even.gnt, bus_even.done, oh_tbl[k]);
      end
      tick();
      tests++; if (bus_even.done !== 1'b1 || bus_even.done_id !== id_tbl[k]) begin
        fails++; $display("FAIL rr_done[%0d]: got done %b id %0d expected 1 %0d", k, bus_even.done, bus_even.done_id, id_tbl[k]);
      end
      tests++; if (bus_even.parity !== par_tbl[k]) begin
        fails++; $display("FAIL rr_parity[%0d]: got %b expected %b", k, bus_even.parity, par_tbl[k]);
      end
      tick();
      tests++; if (bus_even.done !== 1'b0 || bus_even.gnt !== 4'b0000) begin
        fails++; $display("FAIL rr_gap[%0d]: got done %b gnt %b expected 0 0000", k, bus_even.done, bus_even.gnt);
      end
    end
    bus_even.req = 4'b0000;
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    bus_even.din = {8'hFF, 8'h00, 8'h00, 8'h01};
    bus_even.req = 4'b1000;
    tick();
    tests++; if (bus_even.gnt !== 4'b1000) begin fails++; $display("FAIL wrap_first_gnt: got %b expected 1000", bus_even.gnt); end
    bus_even.req = 4'b0000;
    tick();
    tests++; if (bus_even.done_id !== 2'd3) begin fails++; $display("FAIL wrap_first_id: got %0d expected 3", bus_even.done_id); end
    tick();
    bus_even.req = 4'b1001;
    tick();
    tests++; if (bus_even.gnt !== 4'b0001) begin fails++; $display("FAIL wrap_gnt0: got %b expected 0001", bus_even.gnt); end
    tick();
    tests++; if (bus_even.done_id !== 2'd0 || bus_even.parity !== 1'b1) begin
      fails++; $display("FAIL wrap_done0: got id %0d parity %b expected 0 1", bus_even.done_id, bus_even.parity);
    end
    tick();
    tick();
    tests++; if (bus_even.gnt !== 4'b1000) begin fails++; $display("FAIL wrap_gnt3: got %b expected 1000", bus_even.gnt); end
    bus_even.req = 4'b0000;
    tick();
    tests++; if (bus_even.done_id !== 2'd3 || bus_even.parity !== 1'b0) begin
      fails++; $display("FAIL wrap_done3: got id %0d parity %b expected 3 0", bus_even.done_id, bus_even.parity);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus_even.din = {8'h00, 8'h07, 8'h03, 8'h00};
    bus_even.req = 4'b0010;
    tick();
    bus_even.req = 4'b0000;
    tick();
    tick();
    // ptr is now 2; start an op for requester 2 and abort it in CALC.
    bus_even.req = 4'b0100;
    tick();
    tests++; if (bus_even.gnt !== 4'b0100 || bus_even.busy !== 1'b1) begin
      fails++; $display("FAIL mid_pre_gnt: got gnt %b busy %b expected 0100 1", bus_even.gnt, bus_even.busy);
    end
    #2 reset = 1'b1;
    #1;
    tests++; if (bus_even.gnt !== 4'b0000 || bus_even.busy !== 1'b0 || bus_even.done !== 1'b0) begin
      fails++; $display("FAIL mid_async: got gnt %b busy %b done %b expected 0000 0 0", bus_even.gnt, bus_even.busy, bus_even.done);
    end
    bus_even.req = 4'b0000;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus_even.done !== 1'b0 || bus_even.busy !== 1'b0) begin
        fails++; $display("FAIL mid_no_done[%0d]: got done %b busy %b expected 0 0", k, bus_even.done, bus_even.busy);
      end
    end
    // With ptr back at 0, requester 1 beats requester 2.
    bus_even.req = 4'b0110;
    tick();
    tests++; if (bus_even.gnt !== 4'b0010) begin fails++; $display("FAIL mid_ptr_gnt: got %b expected 0010", bus_even.gnt); end
    bus_even.req = 4'b0000;
    tick();
    tests++; if (bus_even.done !== 1'b1 || bus_even.done_id !== 2'd1 || bus_even.parity !== 1'b0) begin
      fails++; $display("FAIL mid_after: got done %b id %0d parity %b expected 1 1 0", bus_even.done, bus_even.done_id, bus_even.parity);
    end
    tick();
  endtask

  task automatic test_late_req();
    bus_even.din = {8'h00, 8'h00, 8'h0E, 8'h01};
    bus_even.req = 4'b0001;
    tick();
    bus_even.req = 4'b0000;
    tick();
    tests++; if (bus_even.done !== 1'b1 || bus_even.done_id !== 2'd0) begin
      fails++; $display("FAIL late_first: got done %b id %0d expected 1 0", bus_even.done, bus_even.done_id);
    end
    bus_even.req = 4'b0010;
    tick();
    tests++; if (bus_even.gnt !== 4'b0000 || bus_even.busy !== 1'b0 || bus_even.done !== 1'b0) begin
      fails++; $display("FAIL late_ignored: got gnt %b busy %b done %b expected 0000 0 0", bus_even.gnt, bus_even.busy, bus_even.done);
    end
    tick();
    tests++; if (bus_even.gnt !== 4'b0010) begin fails++; $display("FAIL late_gnt: got %b expected 0010", bus_even.gnt); end
    bus_even.req = 4'b0000;
    tick();
    tests++; if (bus_even.done !== 1'b1 || bus_even.done_id !== 2'd1 || bus_even.parity !== 1'b1) begin
      fails++; $display("FAIL late_done: got done %b id %0d parity %b expected 1 1 1", bus_even.done, bus_even.done_id, bus_even.parity);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    test_reset();
    test_single();
    test_odd();
    test_round_robin();
    test_ptr_wrap();
    test_reset_mid_op();
    test_late_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_arbiter.md
PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have parameter W, default 8, the data width of each requester.
REQ-003 The block SHALL have parameter ODD, default 0; 0 selects even parity, 1 selects odd parity (result inverted).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req, input, N_REQ bits: level request per requester, held until granted.
REQ-007 The block SHALL have port din, input, N_REQ*W bits: requester i's operand on din[i*W +: W], stable while req[i] is high.
REQ-008 The block SHALL have port gnt, output, N_REQ bits: one-hot grant, one cycle wide.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 The block SHALL have port done_id, output, clog2(N_REQ) bits: index of the requester owning the result.
REQ-012 The block SHALL have port parity, output, 1 bit: XOR reduction of the granted operand, XORed with ODD.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and RESP.
REQ-014 IDLE SHALL behave as follows:
- if req is nonzero, select the winner by round-robin starting at pointer ptr and wrapping modulo N_REQ;
- at the edge, register operand <= winner's din, gnt <= onehot(winner) and id <= winner, then go to CALC;
- if req is zero, remain in IDLE.
REQ-015 CALC SHALL behave as follows:
- gnt is high this cycle;
- at the edge, parity <= ^operand ^ ODD, done <= 1, done_id <= id, gnt <= 0, then go to RESP.
REQ-016 RESP SHALL behave as follows:
- done is high this cycle;
- at the edge, done <= 0, ptr <= (id+1) mod N_REQ, then go to IDLE unconditionally.
REQ-017 Latency SHALL be: request sampled in IDLE at edge t, gnt high in cycle t+1, done/parity valid in cycle t+2. Throughput SHALL be one operation per 3 cycles.
REQ-018 parity and done_id SHALL hold their values until the next done pulse.
REQ-019 req SHALL be ignored in CALC and RESP; pending requests are served on the next IDLE, none lost.
REQ-020 A requester still asserting req in IDLE after its grant SHALL be treated as a new request.
REQ-021 Simultaneous requests SHALL be resolved solely by ptr; the most recently served requester has lowest priority next.
REQ-022 Pointer wrap-around: serving index N_REQ-1 SHALL set ptr to 0.
REQ-023 gnt SHALL be zero or one-hot at all times; done SHALL never be high for two consecutive cycles.

Reset
REQ-024 Asserting reset SHALL asynchronously force: state IDLE, ptr 0, gnt 0, busy 0, done 0, done_id 0, parity 0, operand 0.
REQ-025 Reset asserted during CALC or RESP SHALL abort the operation; no done pulse follows reset deassertion.
REQ-026 Operation after reset deassertion SHALL begin at the first rising clk edge with reset low.

Structure
REQ-027 The state encoding (IDLE/CALC/RESP) and the parity-polarity constants SHALL reside in a shared package, parity_pkg.
REQ-028 The XOR reduction SHALL be one combinational sub-module, parity_xor_w (parameter W), instanced once and shared by all requesters.
REQ-029 All outputs SHALL be registered, with no combinational path from req/din to any output.

Verification
REQ-030 The bench SHALL check single request: N_REQ=4, reset, req=0001, din0=8'hA5 -> gnt=0001 in t+1, done=1, done_id=0, parity=0 in t+2.
REQ-031 The bench SHALL check odd parity: ODD=1, req=0100, din2=8'h07 -> done_id=2, parity=0 (three ones, inverted).
REQ-032 The bench SHALL check round-robin: req=1111 held, operands 8'h01/8'h03/8'h07/8'h0F -> done_id sequence 0,1,2,3,0, parity 1,0,1,0,1, one done every 3 cycles.
REQ-033 The bench SHALL check pointer wrap: serve id 3, then req=1001 -> id 0 granted before id 3.
REQ-034 The bench SHALL check reset mid-operation: reset pulsed during CALC -> gnt=0, busy=0, no done pulse, ptr=0, next req=0010 granted normally.
REQ-035 The bench SHALL check late request: req1 asserted while in RESP -> ignored that cycle, granted on the following IDLE edge, done 2 cycles later.
